// File: rtl/cnn16_pkg.sv
// Shared types and constants for the CNN16 half-precision multiply unit.
package cnn16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    RND  = 2'd3
  } state_t;

  // Operand-pair classification resolved in MUL; anything but SP_NONE skips rounding.
  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_ZERO = 2'd1,
    SP_INF  = 2'd2,
    SP_NAN  = 2'd3
  } special_t;

  localparam int          FP16_BIAS    = 15;
  localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [15:0] FP16_POS_INF = 16'h7C00;

  // Round to nearest, ties to even, from the kept lsb and guard/round/sticky.
  function automatic logic round_up(input logic lsb, input logic guard,
                                    input logic rnd, input logic sticky);
    return guard & (rnd | sticky | lsb);
  endfunction

endpackage

// File: rtl/cnn16_fp16_classify.sv
// Decodes one IEEE-754 half operand; subnormals are reported as zero.
module cnn16_fp16_classify (
  input  logic [15:0] op,
  output logic        sign,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan,
  output logic [10:0] sig
);

  logic [4:0] exp_f;
  logic [9:0] frac;

  assign exp_f   = op[14:10];
  assign frac    = op[9:0];
  assign sign    = op[15];
  assign is_zero = (exp_f == 5'd0);
  assign is_inf  = (exp_f == 5'h1F) && (frac == 10'd0);
  assign is_nan  = (exp_f == 5'h1F) && (frac != 10'd0);
  assign sig     = {1'b1, frac};

endmodule

// File: rtl/cnn16_fp16_mul_unit.sv
// Multi-cycle FP16 multiplier: IDLE -> MUL -> NORM -> RND, one result per 4 cycles.
module cnn16_fp16_mul_unit
  import cnn16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        flag_ovf,
  output logic        flag_unf,
  output logic        flag_inv
);

  state_t state_q, state_d;

  logic [15:0] a_q, b_q;
  logic        a_sign, a_zero, a_inf, a_nan;
  logic        b_sign, b_zero, b_inf, b_nan;
  logic [10:0] a_sig, b_sig;

  // MUL stage outputs
  special_t           spec_m;
  logic               sign_m;
  logic [21:0]        prod_m;
  logic signed [6:0]  exp_m;

  // NORM stage outputs
  special_t           spec_n;
  logic               sign_n;
  logic signed [6:0]  exp_n;
  logic [9:0]         mant_n;
  logic               guard_n, rnd_n, sticky_n;

  cnn16_fp16_classify u_cls_a (
    .op(a_q), .sign(a_sign), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan), .sig(a_sig)
  );

  cnn16_fp16_classify u_cls_b (
    .op(b_q), .sign(b_sign), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan), .sig(b_sig)
  );

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = MUL;
      MUL:     state_d = NORM;
      NORM:    state_d = RND;
      RND:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // MUL: special-case decode, sign, significand product, biased exponent sum.
  special_t          spec_d;
  logic [21:0]       prod_d;
  logic signed [6:0] exp_sum_d;

  always_comb begin
    spec_d = SP_NONE;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) spec_d = SP_NAN;
    else if (a_inf || b_inf)                                       spec_d = SP_INF;
    else if (a_zero || b_zero)                                     spec_d = SP_ZERO;
    prod_d    = {11'd0, a_sig} * {11'd0, b_sig};
    exp_sum_d = {2'b00, a_q[14:10]} + {2'b00, b_q[14:10]} - 7'(FP16_BIAS);
  end

  // NORM: product lies in [1,4); keep 10 fraction bits plus guard/round/sticky.
  logic signed [6:0] exp_norm_d;
  logic [9:0]        mant_norm_d;
  logic              guard_d, rnd_d, sticky_d;

  always_comb begin
    exp_norm_d  = exp_m;
    mant_norm_d = prod_m[19:10];
    guard_d     = prod_m[9];
    rnd_d       = prod_m[8];
    sticky_d    = |prod_m[7:0];
    if (prod_m[21]) begin
      exp_norm_d  = exp_m + 7'sd1;
      mant_norm_d = prod_m[20:11];
      guard_d     = prod_m[10];
      rnd_d       = prod_m[9];
      sticky_d    = |prod_m[8:0];
    end
  end

  // RND: round, then saturate to infinity or flush to zero on the final exponent.
  logic [10:0]       mant_sum;
  logic signed [6:0] exp_rnd;
  logic [15:0]       result_d;
  logic              ovf_d, unf_d, inv_d;

  always_comb begin
    mant_sum = {1'b0, mant_n} + 11'(round_up(mant_n[0], guard_n, rnd_n, sticky_n));
    exp_rnd  = mant_sum[10] ? exp_n + 7'sd1 : exp_n;
    result_d = 16'h0000;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    inv_d    = 1'b0;
    unique case (spec_n)
      SP_NAN: begin
        result_d = FP16_QNAN;
        inv_d    = 1'b1;
      end
      SP_INF:  result_d = {sign_n, FP16_POS_INF[14:0]};
      SP_ZERO: result_d = {sign_n, 15'd0};
      default: begin
        if (exp_rnd >= 7'sd31) begin
          result_d = {sign_n, FP16_EXP_MAX, 10'd0};
          ovf_d    = 1'b1;
        end else if (exp_rnd <= 7'sd0) begin
          result_d = {sign_n, 15'd0};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_n, exp_rnd[4:0], mant_sum[9:0]};
        end
      end
    endcase
  end

  // NOTE: datapath pipeline registers carry no reset; they are only consumed under FSM control.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      a_q <= op_a;
      b_q <= op_b;
    end
    spec_m   <= spec_d;
    sign_m   <= a_sign ^ b_sign;
    prod_m   <= prod_d;
    exp_m    <= exp_sum_d;
    spec_n   <= spec_m;
    sign_n   <= sign_m;
    exp_n    <= exp_norm_d;
    mant_n   <= mant_norm_d;
    guard_n  <= guard_d;
    rnd_n    <= rnd_d;
    sticky_n <= sticky_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done     <= 1'b0;
      result   <= 16'h0000;
      flag_ovf <= 1'b0;
      flag_unf <= 1'b0;
      flag_inv <= 1'b0;
    end else begin
      done <= (state_q == RND);
      if (state_q == RND) begin
        result   <= result_d;
        flag_ovf <= ovf_d;
        flag_unf <= unf_d;
        flag_inv <= inv_d;
      end
    end
  end

endmodule

// File: tb/tb_cnn16_fp16_mul_unit.sv
// Self-checking bench for cnn16_fp16_mul_unit: directed vectors, handshake sequences, random vs model.
module tb_cnn16_fp16_mul_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] op_a = 16'h0000;
  logic [15:0] op_b = 16'h0000;
  logic        busy, done, flag_ovf, flag_unf, flag_inv;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  cnn16_fp16_mul_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result),
    .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inv(flag_inv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [2:0]  flags;  // {ovf, unf, inv}
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer product, then nearest-even rounding by remainder comparison.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b);
    int     ea, eb, e, sh;
    longint p, q, rem, half;
    logic   s, za, zb, ia, ib, na, nb;
    logic [4:0] e5;
    logic [9:0] m10;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 31) && (a[9:0] == 10'd0);
    ib = (eb == 31) && (b[9:0] == 10'd0);
    na = (ea == 31) && (a[9:0] != 10'd0);
    nb = (eb == 31) && (b[9:0] != 10'd0);
    if (na || nb || (ia && zb) || (za && ib)) return {16'h7E00, 3'b001};
    if (ia || ib) return {s, 5'h1F, 10'd0, 3'b000};
    if (za || zb) return {s, 15'd0, 3'b000};
    p = longint'(1024 + int'(a[9:0])) * longint'(1024 + int'(b[9:0]));
    e = ea + eb - 15;
    if (p >= (longint'(1) << 21)) begin sh = 11; e = e + 1; end
    else sh = 10;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && q[0] == 1'b1)) q = q + 1;
    if (q == 2048) begin q = 1024; e = e + 1; end
    if (e >= 31) return {s, 5'h1F, 10'd0, 3'b100};
    if (e <= 0)  return {s, 15'd0, 3'b010};
    e5  = e[4:0];
    m10 = q[9:0];
    return {s, e5, m10, 3'b000};
  endfunction

  // Issues one start at a negedge; returns at the negedge where done is seen (or after the bound).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [18:0] res, output int lat);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    res = {result, flag_ovf, flag_unf, flag_inv};
  endtask

  initial begin
    logic [18:0] got, exp_v;
    logic [15:0] ra, rb;
    int          lat, gap;
    logic        seen;

    vecs[0]  = '{16'h3C00, 16'h4000, 16'h4000, 3'b000};
    vecs[1]  = '{16'h3E00, 16'h3E00, 16'h4080, 3'b000};
    vecs[2]  = '{16'hC000, 16'h3C00, 16'hC000, 3'b000};
    vecs[3]  = '{16'h3C01, 16'h3C01, 16'h3C02, 3'b000};
    vecs[4]  = '{16'h7BFF, 16'h7BFF, 16'h7C00, 3'b100};
    vecs[5]  = '{16'h0400, 16'h3800, 16'h0000, 3'b010};
    vecs[6]  = '{16'h7C00, 16'h0000, 16'h7E00, 3'b001};
    vecs[7]  = '{16'hFC00, 16'h4000, 16'hFC00, 3'b000};
    vecs[8]  = '{16'h8000, 16'h4000, 16'h8000, 3'b000};
    vecs[9]  = '{16'h0001, 16'h4000, 16'h0000, 3'b000};
    vecs[10] = '{16'h7C01, 16'h3C00, 16'h7E00, 3'b001};
    vecs[11] = '{16'h3C01, 16'h3E00, 16'h3E02, 3'b000};
    vecs[12] = '{16'h3C03, 16'h3E00, 16'h3E04, 3'b000};
    vecs[13] = '{16'h3C00, 16'h7C00, 16'h7C00, 3'b000};

    repeat (3) @(negedge clk);
    check("reset_outputs", {11'd0, busy, done, result, flag_ovf, flag_unf, flag_inv}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].a, vecs[i].b, got, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d_result", i), {13'd0, got}, {13'd0, vecs[i].res, vecs[i].flags});
      @(negedge clk);
      check($sformatf("vec%0d_pulse_hold", i), {15'd0, done, result},
            {15'd0, 1'b0, vecs[i].res});
    end

    // Second start while busy must be dropped, not queued.
    op_a = 16'h3C00; op_b = 16'h4000; start = 1'b1;
    @(negedge clk);
    op_a = 16'h4400; op_b = 16'h4400;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("busy_start_latency", 32'(lat), 32'd3);
    check("busy_start_result", {16'd0, result}, {16'd0, 16'h4000});
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("busy_start_no_extra_done", {31'd0, seen}, 32'd0);

    // Start in the done cycle: next done exactly 4 cycles after the first.
    run_op(16'h3C00, 16'h4000, got, lat);
    check("b2b_first_latency", 32'(lat), 32'd3);
    op_a = 16'h4000; op_b = 16'h4000; start = 1'b1;
    gap = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      gap++;
    end while (!done && gap < 12);
    check("b2b_gap", 32'(gap), 32'd4);
    check("b2b_result", {16'd0, result}, {16'd0, 16'h4400});

    // Operand changes after acceptance do not disturb the operation in flight.
    op_a = 16'h4000; op_b = 16'h4200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a = 16'hFFFF; op_b = 16'h0000;
    lat = 0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("opchange_latency", 32'(lat), 32'd3);
    check("opchange_result", {13'd0, result, flag_ovf, flag_unf, flag_inv},
          {13'd0, 16'h4600, 3'b000});

    // Reset during NORM aborts the operation and clears the outputs.
    @(negedge clk);
    op_a = 16'h4200; op_b = 16'h4200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_busy_before_reset", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_outputs_zero", {11'd0, busy, done, result, flag_ovf, flag_unf, flag_inv}, 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", {31'd0, seen}, 32'd0);
    run_op(16'h4200, 16'h4200, got, lat);
    check("after_abort_latency", 32'(lat), 32'd3);
    check("after_abort_result", {13'd0, got}, {13'd0, 16'h4880, 3'b000});

    // Random operands against the reference model.
    for (int n = 0; n < 300; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 1) == 1) ra[14:10] = 5'($urandom_range(8, 22));
      if ($urandom_range(0, 1) == 1) rb[14:10] = 5'($urandom_range(8, 22));
      exp_v = model(ra, rb);
      run_op(ra, rb, got, lat);
      check($sformatf("rand%0d_%h_x_%h_latency", n, ra, rb), 32'(lat), 32'd3);
      check($sformatf("rand%0d_%h_x_%h", n, ra, rb), {13'd0, got}, {13'd0, exp_v});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn16_fp16_mul_unit.md
CNN16_FP16_MUL_UNIT -- requirements
Module: cnn16_fp16_mul_unit

Interface
REQ-001 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-002 Port rst_n, input, 1: synchronous, active-low reset, sampled on rising clk.
REQ-003 Port start, input, 1: request one multiply; honoured only in IDLE.
REQ-004 Port op_a, input, 16: IEEE-754 half operand A (datapath FPLOAD).
REQ-005 Port op_b, input, 16: IEEE-754 half operand B (datapath AC).
REQ-006 Port busy, output, 1: high in every state except IDLE.
REQ-007 Port done, output, 1: one-cycle pulse when result is valid; drives datapath FPMUL_Load.
REQ-008 Port result, output, 16: product; drives datapath fp_mul_result; holds until the next done.
REQ-009 Port flag_ovf, output, 1: overflow to infinity on last result; updates with done, sticky until the next done.
REQ-010 Port flag_unf, output, 1: nonzero result flushed to zero on last result; same timing as flag_ovf.
REQ-011 Port flag_inv, output, 1: NaN produced on last result; same timing as flag_ovf.

Function
REQ-012 FSM states IDLE, MUL, NORM, RND; transitions IDLE->MUL on start, MUL->NORM, NORM->RND, RND->IDLE, all unconditional after IDLE.
REQ-013 On the edge leaving IDLE, op_a and op_b are latched; later input changes have no effect on the operation in flight.
REQ-014 start is ignored while busy; no queueing.
REQ-015 Latency: start accepted at edge k; result, flags and done are registered at edge k+3; done is high for exactly one cycle.
REQ-016 State is IDLE during the done cycle, so a start in that cycle is accepted; maximum throughput is one result per 4 cycles.
REQ-017 MUL computes sign = a[15]^b[15] and the 22-bit product of the 11-bit significands with the hidden 1; exponent sum is kept 7-bit signed: ea+eb-15.
REQ-018 NORM: if product bit 21 is set, shift right 1 and increment the exponent; form the 10-bit mantissa plus guard, round and sticky bits.
REQ-019 RND rounds to nearest, ties to even; a mantissa carry-out increments the exponent.
REQ-020 Final exponent >= 31 gives signed infinity (s,5'h1F,0) with flag_ovf=1.
REQ-021 Final exponent <= 0 gives signed zero with flag_unf=1; subnormal results are not produced.
REQ-022 Subnormal inputs (exponent 0) are treated as signed zero.
REQ-023 Zero times finite gives signed zero with no flags.
REQ-024 A NaN operand, or infinity times zero, gives canonical NaN 16'h7E00 with flag_inv=1.
REQ-025 Infinity times a nonzero finite value or infinity gives signed infinity with no flags.
REQ-026 Special-case results bypass rounding but keep the same 3-cycle latency.

Reset
REQ-027 With rst_n low at a clock edge: state=IDLE, busy=0, done=0, result=16'h0000, all flags=0.
REQ-028 Reset asserted mid-operation aborts the operation; no done is produced for it.
REQ-029 rst_n has priority over start at the same edge.

Structure
REQ-030 Package cnn16_pkg holds the FSM state typedef and these constants: FP16_BIAS=15, FP16_EXP_MAX=5'h1F, FP16_QNAN=16'h7E00, FP16_POS_INF=16'h7C00.
REQ-031 One combinational sub-module, cnn16_fp16_classify, decodes an operand into is_zero, is_inf, is_nan and the significand with hidden bit.
REQ-032 Two classify instances are used; the rest lives in cnn16_fp16_mul_unit.

Verification
REQ-033 Basic multiply: start with 3C00 x 4000 -> done exactly 3 cycles after start, result=4000, no flags.
REQ-034 Normalisation, sign and rounding:
- 3E00 x 3E00 -> 4080.
- C000 x 3C00 -> C000.
- 3C01 x 3C01 -> 3C02 (round-nearest with sticky).
REQ-035 Exceptions:
- 7BFF x 7BFF -> 7C00 with flag_ovf.
- 0400 x 3800 -> 0000 with flag_unf.
- 7C00 x 0000 -> 7E00 with flag_inv.
- FC00 x 4000 -> FC00, no flags.
REQ-036 Handshake:
- A second start while busy is ignored.
- A start during the done cycle gives the next done 4 cycles after the first.
- Changing op_a/op_b after acceptance leaves result unchanged.
REQ-037 Reset: rst_n low during NORM -> no done, all outputs 0, next start behaves normally.
